// File: rtl/memory_access_stage.sv
// MEM pipeline stage: registers execute results and runs loads/stores over a
// req/ack data-memory port with byte-lane strobes, load extension and misalignment traps.
module memory_access_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        in_isLoad,
    input  logic                        in_isStore,
    input  logic [1:0]                  in_memSize,
    input  logic                        in_isUnsigned,
    input  logic [ADDR_WIDTH-1:0]       in_addr,
    input  logic [DATA_WIDTH-1:0]       in_storeData,
    input  logic [REG_ADDR_WIDTH-1:0]   in_rdAddr,
    input  logic                        in_rdWrite,
    input  logic                        flush,
    output logic                        in_ready,
    output logic                        stall,
    output logic                        dmem_req,
    output logic                        dmem_we,
    output logic [ADDR_WIDTH-1:0]       dmem_addr,
    output logic [DATA_WIDTH/8-1:0]     dmem_be,
    output logic [DATA_WIDTH-1:0]       dmem_wdata,
    input  logic                        dmem_ack,
    input  logic [DATA_WIDTH-1:0]       dmem_rdata,
    output logic                        out_valid,
    output logic [REG_ADDR_WIDTH-1:0]   out_rdAddr,
    output logic                        out_rdWrite,
    output logic [DATA_WIDTH-1:0]       out_rdData,
    output logic                        misaligned_exc,
    output logic [ADDR_WIDTH-1:0]       exc_addr
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCESS   = 2'd1;
    localparam logic [1:0] COMPLETE = 2'd2;

    logic [1:0]                state_q, state_d;
    logic                      flush_pending_q, flush_pending_d;
    logic [1:0]                off_q, off_d;
    logic [1:0]                size_q, size_d;
    logic                      unsigned_q, unsigned_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                      rd_write_q, rd_write_d;

    logic                      dmem_req_q, dmem_req_d;
    logic                      dmem_we_q, dmem_we_d;
    logic [ADDR_WIDTH-1:0]     dmem_addr_q, dmem_addr_d;
    logic [DATA_WIDTH/8-1:0]   dmem_be_q, dmem_be_d;
    logic [DATA_WIDTH-1:0]     dmem_wdata_q, dmem_wdata_d;

    logic                      out_valid_q, out_valid_d;
    logic [REG_ADDR_WIDTH-1:0] out_rd_addr_q, out_rd_addr_d;
    logic                      out_rd_write_q, out_rd_write_d;
    logic [DATA_WIDTH-1:0]     out_rd_data_q, out_rd_data_d;
    logic                      misaligned_exc_q, misaligned_exc_d;
    logic [ADDR_WIDTH-1:0]     exc_addr_q, exc_addr_d;

    logic                      accept;
    logic                      is_mem;
    logic                      misaligned;
    logic [DATA_WIDTH/8-1:0]   be_calc;
    logic [DATA_WIDTH-1:0]     wdata_calc;
    logic [DATA_WIDTH-1:0]     ld_shift;
    logic [DATA_WIDTH-1:0]     ld_ext;

    assign in_ready = (state_q == IDLE);
    assign stall    = ~in_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign is_mem   = in_isLoad | in_isStore;

    always_comb begin
        misaligned = (in_memSize == 2'd3)
                   | ((in_memSize == 2'd1) & in_addr[0])
                   | ((in_memSize == 2'd2) & (in_addr[1:0] != 2'b00));
        case (in_memSize)
            2'd0:    be_calc = 4'b0001 << in_addr[1:0];
            2'd1:    be_calc = 4'b0011 << in_addr[1:0];
            default: be_calc = 4'hF;
        endcase
        case (in_memSize)
            2'd0:    wdata_calc = {4{in_storeData[7:0]}};
            2'd1:    wdata_calc = {2{in_storeData[15:0]}};
            default: wdata_calc = in_storeData;
        endcase
    end

    // Returned word is shifted down to the accessed lane, then extended.
    always_comb begin
        ld_shift = dmem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    ld_ext = {{24{~unsigned_q & ld_shift[7]}}, ld_shift[7:0]};
            2'd1:    ld_ext = {{16{~unsigned_q & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        flush_pending_d  = flush_pending_q;
        off_d            = off_q;
        size_d           = size_q;
        unsigned_d       = unsigned_q;
        rd_addr_d        = rd_addr_q;
        rd_write_d       = rd_write_q;
        dmem_req_d       = dmem_req_q;
        dmem_we_d        = dmem_we_q;
        dmem_addr_d      = dmem_addr_q;
        dmem_be_d        = dmem_be_q;
        dmem_wdata_d     = dmem_wdata_q;
        out_valid_d      = 1'b0;
        out_rd_addr_d    = out_rd_addr_q;
        out_rd_write_d   = out_rd_write_q;
        out_rd_data_d    = out_rd_data_q;
        misaligned_exc_d = 1'b0;
        exc_addr_d       = exc_addr_q;

        case (state_q)
            IDLE: begin
                flush_pending_d = 1'b0;
                if (accept) begin
                    if (!is_mem) begin
                        out_valid_d    = 1'b1;
                        out_rd_addr_d  = in_rdAddr;
                        out_rd_write_d = in_rdWrite;
                        out_rd_data_d  = in_addr;
                    end else if (misaligned) begin
                        out_valid_d      = 1'b1;
                        out_rd_addr_d    = in_rdAddr;
                        out_rd_write_d   = 1'b0;
                        misaligned_exc_d = 1'b1;
                        exc_addr_d       = in_addr;
                    end else begin
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = in_isStore & ~in_isLoad;
                        dmem_addr_d  = {in_addr[ADDR_WIDTH-1:2], 2'b00};
                        dmem_be_d    = be_calc;
                        dmem_wdata_d = wdata_calc;
                        off_d        = in_addr[1:0];
                        size_d       = in_memSize;
                        unsigned_d   = in_isUnsigned;
                        rd_addr_d    = in_rdAddr;
                        rd_write_d   = in_rdWrite & in_isLoad;
                        state_d      = ACCESS;
                    end
                end
            end
            // The bus forbids withdrawing a request, so a flush here only
            // suppresses the writeback once the access finishes.
            ACCESS: begin
                if (flush) begin
                    flush_pending_d = 1'b1;
                end
                if (dmem_ack) begin
                    dmem_req_d     = 1'b0;
                    out_valid_d    = ~(flush_pending_q | flush);
                    out_rd_addr_d  = rd_addr_q;
                    out_rd_write_d = rd_write_q & ~(flush_pending_q | flush);
                    out_rd_data_d  = ld_ext;
                    state_d        = COMPLETE;
                end
            end
            COMPLETE: begin
                flush_pending_d = 1'b0;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            flush_pending_q  <= 1'b0;
            off_q            <= '0;
            size_q           <= '0;
            unsigned_q       <= 1'b0;
            rd_addr_q        <= '0;
            rd_write_q       <= 1'b0;
            dmem_req_q       <= 1'b0;
            dmem_we_q        <= 1'b0;
            dmem_addr_q      <= '0;
            dmem_be_q        <= '0;
            dmem_wdata_q     <= '0;
            out_valid_q      <= 1'b0;
            out_rd_addr_q    <= '0;
            out_rd_write_q   <= 1'b0;
            out_rd_data_q    <= '0;
            misaligned_exc_q <= 1'b0;
            exc_addr_q       <= '0;
        end else begin
            state_q          <= state_d;
            flush_pending_q  <= flush_pending_d;
            off_q            <= off_d;
            size_q           <= size_d;
            unsigned_q       <= unsigned_d;
            rd_addr_q        <= rd_addr_d;
            rd_write_q       <= rd_write_d;
            dmem_req_q       <= dmem_req_d;
            dmem_we_q        <= dmem_we_d;
            dmem_addr_q      <= dmem_addr_d;
            dmem_be_q        <= dmem_be_d;
            dmem_wdata_q     <= dmem_wdata_d;
            out_valid_q      <= out_valid_d;
            out_rd_addr_q    <= out_rd_addr_d;
            out_rd_write_q   <= out_rd_write_d;
            out_rd_data_q    <= out_rd_data_d;
            misaligned_exc_q <= misaligned_exc_d;
            exc_addr_q       <= exc_addr_d;
        end
    end

    assign dmem_req       = dmem_req_q;
    assign dmem_we        = dmem_we_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_be        = dmem_be_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign out_valid      = out_valid_q;
    assign out_rdAddr     = out_rd_addr_q;
    assign out_rdWrite    = out_rd_write_q;
    assign out_rdData     = out_rd_data_q;
    assign misaligned_exc = misaligned_exc_q;
    assign exc_addr       = exc_addr_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: ALU pass-through, loads, stores,
// misalignment, flush during an access and asynchronous reset mid-access.
module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid, inIsLoad, inIsStore, inIsUnsigned, inRdWrite, flush;
    logic [1:0]  inMemSize;
    logic [31:0] inAddr, inStoreData;
    logic [4:0]  inRdAddr;
    logic        inReady, stall;
    logic        dmemReq, dmemWe, dmemAck;
    logic [31:0] dmemAddr, dmemWdata, dmemRdata;
    logic [3:0]  dmemBe;
    logic        outValid, outRdWrite, misalignedExc;
    logic [4:0]  outRdAddr;
    logic [31:0] outRdData, excAddr;

    int checks = 0;
    int errors = 0;
    int stallCount;

    memory_access_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_isLoad(inIsLoad), .in_isStore(inIsStore),
        .in_memSize(inMemSize), .in_isUnsigned(inIsUnsigned), .in_addr(inAddr),
        .in_storeData(inStoreData), .in_rdAddr(inRdAddr), .in_rdWrite(inRdWrite),
        .flush(flush), .in_ready(inReady), .stall(stall),
        .dmem_req(dmemReq), .dmem_we(dmemWe), .dmem_addr(dmemAddr),
        .dmem_be(dmemBe), .dmem_wdata(dmemWdata), .dmem_ack(dmemAck),
        .dmem_rdata(dmemRdata), .out_valid(outValid), .out_rdAddr(outRdAddr),
        .out_rdWrite(outRdWrite), .out_rdData(outRdData),
        .misaligned_exc(misalignedExc), .exc_addr(excAddr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic ld, input logic st,
                                 input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [4:0] rd, input logic rdw);
        inValid      = v;
        inIsLoad     = ld;
        inIsStore    = st;
        inMemSize    = sz;
        inIsUnsigned = uns;
        inAddr       = addr;
        inStoreData  = data;
        inRdAddr     = rd;
        inRdWrite    = rdw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds ack low until request cycle ackCycle, counting stall cycles and
    // confirming the request stays up; returns in the COMPLETE cycle.
    task automatic runAccess(input int ackCycle, input logic [31:0] rdata,
                             input string tag);
        for (int c = 1; c <= ackCycle; c++) begin
            if (stall) stallCount++;
            checkOutput({tag, "_req_held"}, {31'd0, dmemReq}, 32'd1);
            if (c == ackCycle) begin
                dmemAck   = 1'b1;
                dmemRdata = rdata;
            end
            tick();
            dmemAck   = 1'b0;
            dmemRdata = 32'h0;
        end
        if (stall) stallCount++;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        dmemAck   = 1'b0;
        dmemRdata = 32'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        #2;
        checkOutput("rst_out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("rst_dmem_req", {31'd0, dmemReq}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, inReady}, 32'd1);
        checkOutput("rst_rd_data", outRdData, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // 1: ALU op
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("alu_valid", {31'd0, outValid}, 32'd1);
        checkOutput("alu_data", outRdData, 32'h1234);
        checkOutput("alu_rd", {27'd0, outRdAddr}, 32'd5);
        checkOutput("alu_stall", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("alu_valid_drop", {31'd0, outValid}, 32'd0);

        // 2: LB with ack on the third request cycle
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 5'd6, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("lb_be", {28'd0, dmemBe}, 32'h4);
        checkOutput("lb_addr", dmemAddr, 32'h100);
        checkOutput("lb_we", {31'd0, dmemWe}, 32'd0);
        stallCount = 0;
        runAccess(3, 32'h80FF_0000, "lb");
        checkOutput("lb_valid", {31'd0, outValid}, 32'd1);
        checkOutput("lb_data", outRdData, 32'hFFFF_FFFF);
        checkOutput("lb_rd", {27'd0, outRdAddr}, 32'd6);
        checkOutput("lb_stall_cycles", stallCount, 32'd4);
        tick();
        checkOutput("lb_ready_again", {31'd0, inReady}, 32'd1);
        checkOutput("lb_valid_drop", {31'd0, outValid}, 32'd0);

        // 3: LHU, minimum latency
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 5'd7, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("lhu_be", {28'd0, dmemBe}, 32'hC);
        runAccess(1, 32'h80FF_0000, "lhu");
        checkOutput("lhu_valid", {31'd0, outValid}, 32'd1);
        checkOutput("lhu_data", outRdData, 32'h0000_80FF);
        checkOutput("lhu_rdwrite", {31'd0, outRdWrite}, 32'd1);
        tick();

        // 4: SH at 0x106
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 32'h106, 32'h1234_ABCD, 5'd8, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("sh_addr", dmemAddr, 32'h104);
        checkOutput("sh_be", {28'd0, dmemBe}, 32'hC);
        checkOutput("sh_wdata", dmemWdata, 32'hABCD_ABCD);
        checkOutput("sh_we", {31'd0, dmemWe}, 32'd1);
        runAccess(1, 32'h0, "sh");
        checkOutput("sh_valid", {31'd0, outValid}, 32'd1);
        checkOutput("sh_rdwrite", {31'd0, outRdWrite}, 32'd0);
        tick();

        // LW aligned; also load+store together behaves as load
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h200, 32'h5555_5555, 5'd9, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("lw_be", {28'd0, dmemBe}, 32'hF);
        checkOutput("lw_we", {31'd0, dmemWe}, 32'd0);
        runAccess(2, 32'hDEAD_BEEF, "lw");
        checkOutput("lw_data", outRdData, 32'hDEAD_BEEF);
        tick();

        // SB lane replication at offset 3
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h203, 32'h0000_00A5, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("sb_be", {28'd0, dmemBe}, 32'h8);
        checkOutput("sb_wdata", dmemWdata, 32'hA5A5_A5A5);
        runAccess(1, 32'h0, "sb");
        tick();

        // 5: misaligned LW
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 5'd10, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("mis_req", {31'd0, dmemReq}, 32'd0);
        checkOutput("mis_exc", {31'd0, misalignedExc}, 32'd1);
        checkOutput("mis_exc_addr", excAddr, 32'h101);
        checkOutput("mis_valid", {31'd0, outValid}, 32'd1);
        checkOutput("mis_rdwrite", {31'd0, outRdWrite}, 32'd0);
        checkOutput("mis_stall", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("mis_exc_pulse", {31'd0, misalignedExc}, 32'd0);

        // Flush with in_valid in IDLE drops the op; stray ack is ignored
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 5'd11, 1'b1);
        flush   = 1'b1;
        dmemAck = 1'b1;
        tick();
        flush   = 1'b0;
        dmemAck = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("flush_idle_req", {31'd0, dmemReq}, 32'd0);
        checkOutput("flush_idle_valid", {31'd0, outValid}, 32'd0);
        checkOutput("flush_idle_ready", {31'd0, inReady}, 32'd1);

        // 6: SW flushed during ACCESS still completes on the bus
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h300, 32'h1122_3344, 5'd12, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        flush = 1'b1;
        checkOutput("sw_req", {31'd0, dmemReq}, 32'd1);
        tick();
        flush = 1'b0;
        runAccess(1, 32'h0, "sw_flush");
        checkOutput("sw_flush_valid", {31'd0, outValid}, 32'd0);
        checkOutput("sw_flush_wdata", dmemWdata, 32'h1122_3344);
        tick();

        // Async reset mid-ACCESS
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 5'd13, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("rst_mid_req_before", {31'd0, dmemReq}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_req", {31'd0, dmemReq}, 32'd0);
        checkOutput("rst_mid_ready", {31'd0, inReady}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("rst_mid_valid", {31'd0, outValid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
